idp_enc_sched: RTL

IDP_ENC_SCHED -- requirements
Module: idp_enc_sched

---
 rtl/idp_enc_sched.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/idp_enc_sched.sv
// idp_enc_sched: two-requester front end for the 33-bit IDP encoder.
// Requests are granted round-robin and range-checked. Each legal word is
// launched into the external encoder, which has a one-cycle registered
// latency. The resulting code is queued with its source id and returned in
// acceptance order. Issue is credit-limited, so every word in flight already
// owns a FIFO slot and the output FIFO can never overflow.

`ifndef IBLEN33
`define IBLEN33 24
`endif
`ifndef FNS35
`define FNS35 9227465
`endif
`ifndef FNS30
`define FNS30 832040
`endif

module idp_enc_sched #(
  parameter int          DIN_W  = `IBLEN33,                  // encoder input width
  parameter int unsigned DMAX   = `FNS35 + 2*`FNS30 - 1,     // largest legal input
  parameter int          FIFO_D = 4                          // power of two, >= 4
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             s0_valid,
  input  logic [DIN_W-1:0] s0_data,
  output logic             s0_ready,
  input  logic             s1_valid,
  input  logic [DIN_W-1:0] s1_data,
  output logic             s1_ready,
  output logic [DIN_W-1:0] enc_din,
  input  logic [32:0]      enc_code,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [32:0]      m_code,
  output logic             m_id,
  output logic             err_pulse,
  output logic [7:0]       err_cnt
);

  localparam int AW = $clog2(FIFO_D);
  localparam int CW = AW + 2;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_D);

  // Issue / stage registers
  logic             rr_reg;
  logic [DIN_W-1:0] enc_din_reg;
  logic             v1_reg;
  logic             id1_reg;
  logic             v2_reg;
  logic             id2_reg;
  logic             err_pulse_reg;
  logic [7:0]       err_cnt_reg;

  // Output FIFO
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      fifo_cnt_reg;
  logic [32:0]      mem_code [FIFO_D];
  logic             mem_id   [FIFO_D];
  logic [FIFO_D-1:0] wr_en;

  // Combinational control
  logic [CW-1:0]    occupancy;
  logic             issue_ok;
  logic             grant;
  logic             accept;
  logic             out_of_range;
  logic [DIN_W-1:0] grant_data;
  logic             push;
  logic             pop;

  // Queued plus in-flight words; a new issue needs a guaranteed free slot.
  assign occupancy = CW'(fifo_cnt_reg) + CW'(v1_reg) + CW'(v2_reg);
  assign issue_ok  = occupancy < CW'(FIFO_D);

  // Round-robin only matters under contention; a lone requester wins outright.
  assign grant      = (s0_valid & s1_valid) ? rr_reg : s1_valid;
  assign grant_data = grant ? s1_data : s0_data;

  // Ready is forced low while reset is asserted.
  assign s0_ready = rst_n & issue_ok & ~grant;
  assign s1_ready = rst_n & issue_ok &  grant;
  assign accept   = (s0_valid & s0_ready) | (s1_valid & s1_ready);

  assign out_of_range = 33'(grant_data) > 33'(DMAX);

  assign push    = v2_reg;
  assign m_valid = (fifo_cnt_reg != '0);
  assign pop     = m_valid & m_ready;

  assign enc_din   = enc_din_reg;
  assign err_pulse = err_pulse_reg;
  assign err_cnt   = err_cnt_reg;
  assign m_code    = mem_code[rd_ptr_reg];
  assign m_id      = mem_id[rd_ptr_reg];

  // Arbitration, range check and launch of legal words into the encoder.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rr_reg        <= 1'b0;
      enc_din_reg   <= '0;
      v1_reg        <= 1'b0;
      id1_reg       <= 1'b0;
      err_pulse_reg <= 1'b0;
      err_cnt_reg   <= '0;
    end else begin
      v1_reg        <= accept & ~out_of_range;
      err_pulse_reg <= accept &  out_of_range;
      if (accept) begin
        rr_reg <= ~grant;
        if (!out_of_range) begin
          enc_din_reg <= grant_data;
          id1_reg     <= grant;
        end else if (err_cnt_reg != 8'hFF) begin
          err_cnt_reg <= err_cnt_reg + 8'd1;
        end
      end
    end
  end

  // Second stage tracks the word whose code appears on enc_code this cycle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      v2_reg  <= 1'b0;
      id2_reg <= 1'b0;
    end else begin
      v2_reg  <= v1_reg;
      id2_reg <= id1_reg;
    end
  end

  // FIFO pointers and fill count; simultaneous push and pop leave count alone.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  // Per-entry write enables decoded from the write pointer.
  genvar gi;
  generate
    for (gi = 0; gi < FIFO_D; gi++) begin : g_wr_en
      assign wr_en[gi] = push & (wr_ptr_reg == AW'(gi));
    end
  endgenerate

  // FIFO storage; contents need no reset because the count gates visibility.
  always_ff @(posedge clock) begin
    for (int i = 0; i < FIFO_D; i++) begin
      if (wr_en[i]) begin
        mem_code[i] <= enc_code;
        mem_id[i]   <= id2_reg;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!rst_n)
    !(push && !pop && (fifo_cnt_reg == FULL_CNT)));

  a_ready_onehot: assert property (@(posedge clock) !(s0_ready && s1_ready));

endmodule
